// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports (same-cycle write bypass),
// one synchronous write port, a per-register pending-write scoreboard and a sequential
// clear engine. Register 0 is hard-wired to zero and is never pending.
module regfile_sb #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REGS   = 4,
    localparam int unsigned ADDR_BITS = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_BITS-1:0]  rd_addr1,
    input  logic [ADDR_BITS-1:0]  rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  rd_busy1,
    output logic                  rd_busy2,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rsv_en,
    input  logic [ADDR_BITS-1:0]  rsv_addr,
    input  logic                  clr_req,
    output logic                  clr_busy
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    // Only registers 1..NUM_REGS-1 hold state; register 0 is implied zero.
    logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:1]                 pend_q, pend_d;

    assign clr_busy = (state_q == StClear);

    // Read ports: stored value and pend flag, then bypass (idle) or forced busy (clear).
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        rd_busy1 = 1'b0;
        rd_busy2 = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_addr1 == ADDR_BITS'(i)) begin
                rd_data1 = regs_q[i];
                rd_busy1 = pend_q[i];
            end
            if (rd_addr2 == ADDR_BITS'(i)) begin
                rd_data2 = regs_q[i];
                rd_busy2 = pend_q[i];
            end
        end
        if (state_q == StIdle) begin
            // A writeback in flight is forwarded and therefore no longer a hazard.
            if (wr_en && (wr_addr == rd_addr1) && (rd_addr1 != '0)) begin
                rd_data1 = wr_data;
                rd_busy1 = 1'b0;
            end
            if (wr_en && (wr_addr == rd_addr2) && (rd_addr2 != '0)) begin
                rd_data2 = wr_data;
                rd_busy2 = 1'b0;
            end
        end else begin
            if (rd_addr1 != '0) rd_busy1 = 1'b1;
            if (rd_addr2 != '0) rd_busy2 = 1'b1;
        end
    end

    // Next state: write/reserve in idle, one register wiped per cycle during a sweep.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (wr_en && (wr_addr == ADDR_BITS'(i))) begin
                        regs_d[i] = wr_data;
                        pend_d[i] = 1'b0;
                    end
                    // Applied after the write clear so a same-edge reserve wins.
                    if (rsv_en && (rsv_addr == ADDR_BITS'(i))) begin
                        pend_d[i] = 1'b1;
                    end
                end
                if (clr_req) begin
                    state_d = StClear;
                    idx_d   = ADDR_BITS'(1);
                end
            end
            StClear: begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (idx_q == ADDR_BITS'(i)) begin
                        regs_d[i] = '0;
                        pend_d[i] = 1'b0;
                    end
                end
                idx_d = idx_q + ADDR_BITS'(1);
                if (idx_q == ADDR_BITS'(NUM_REGS - 1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= ADDR_BITS'(1);
            regs_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            regs_q  <= regs_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against a behavioural model;
// a second 32-bit x 16 instance covers the wider parameter set.
module tb_regfile_sb;

    localparam int DW = 64;
    localparam int NR = 4;
    localparam int AB = 2;

    localparam int SDW = 32;
    localparam int SNR = 16;
    localparam int SAB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AB-1:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [DW-1:0] wr_data, rd_data1, rd_data2;
    logic          rd_busy1, rd_busy2, wr_en, rsv_en, clr_req, clr_busy;

    logic [SAB-1:0] s_rd_addr1, s_rd_addr2, s_wr_addr, s_rsv_addr;
    logic [SDW-1:0] s_wr_data, s_rd_data1, s_rd_data2;
    logic           s_rd_busy1, s_rd_busy2, s_wr_en, s_rsv_en, s_clr_req, s_clr_busy;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    regfile_sb #(.DATA_WIDTH(SDW), .NUM_REGS(SNR)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(s_rd_addr1), .rd_addr2(s_rd_addr2),
        .rd_data1(s_rd_data1), .rd_data2(s_rd_data2),
        .rd_busy1(s_rd_busy1), .rd_busy2(s_rd_busy2),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr),
        .clr_req(s_clr_req), .clr_busy(s_clr_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: register contents, pending flags, and the next register a sweep
    // will wipe (0 when no sweep is running).
    logic [DW-1:0] m_reg[NR];
    bit            m_pend[NR];
    int            m_sweep;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_sweep = 0;
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AB-1:0] a);
        if (a == 0) return '0;
        if (m_sweep != 0) return m_reg[a];
        if (wr_en && wr_addr == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AB-1:0] a);
        if (a == 0) return 1'b0;
        if (m_sweep != 0) return 1'b1;
        if (wr_en && wr_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_edge();
        if (m_sweep != 0) begin
            m_reg[m_sweep]  = '0;
            m_pend[m_sweep] = 1'b0;
            m_sweep = (m_sweep == NR - 1) ? 0 : m_sweep + 1;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_reg[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
            if (clr_req) m_sweep = 1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check("rd_data1", rd_data1, exp_data(rd_addr1));
        check("rd_data2", rd_data2, exp_data(rd_addr2));
        check("rd_busy1", rd_busy1, exp_busy(rd_addr1));
        check("rd_busy2", rd_busy2, exp_busy(rd_addr2));
        check("clr_busy", clr_busy, m_sweep != 0);
    endtask

    task automatic commit();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        commit();
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
    endtask

    task automatic write(input logic [AB-1:0] a, input logic [DW-1:0] d);
        idle_inputs();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        idle_inputs();
    endtask

    initial begin
        int cnt;
        idle_inputs();
        rd_addr1 = '0; rd_addr2 = '0;
        s_rd_addr1 = '0; s_rd_addr2 = '0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
        s_rsv_en = 1'b0; s_rsv_addr = '0; s_clr_req = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #16 rst_n = 1'b1;

        // Register 0 ignores writes.
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 64'hDEAD; rd_addr1 = 2'd0;
        sample();
        check("zero_data", rd_data1, 64'h0);
        check("zero_busy", rd_busy1, 1'b0);
        commit();
        idle_inputs();
        sample();
        check("zero_after", rd_data1, 64'h0);
        commit();

        // Bypass then stored value.
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 64'h1234; rd_addr1 = 2'd2;
        sample();
        check("bypass", rd_data1, 64'h1234);
        commit();
        idle_inputs();
        sample();
        check("stored", rd_data1, 64'h1234);
        commit();

        // Scoreboard: reserve, writeback, same-edge reserve+write.
        rsv_en = 1'b1; rsv_addr = 2'd3; rd_addr2 = 2'd3;
        step();
        idle_inputs();
        sample();
        check("rsv_busy", rd_busy2, 1'b1);
        commit();
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 64'h77;
        sample();
        check("wb_busy", rd_busy2, 1'b0);
        check("wb_data", rd_data2, 64'h77);
        commit();
        idle_inputs();
        sample();
        check("wb_busy_after", rd_busy2, 1'b0);
        commit();
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 64'h88; rsv_en = 1'b1; rsv_addr = 2'd3;
        step();
        idle_inputs();
        sample();
        check("rsv_wins", rd_busy2, 1'b1);
        commit();

        // Clear sweep with a pending register and an ignored write.
        write(2'd1, 64'd5);
        write(2'd2, 64'd6);
        write(2'd3, 64'd7);
        rsv_en = 1'b1; rsv_addr = 2'd2;
        step();
        idle_inputs();
        clr_req = 1'b1;
        step();
        idle_inputs();
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            wr_en = (c < 3); wr_addr = 2'd1; wr_data = 64'hFF;
            rd_addr1 = 2'd1; rd_addr2 = 2'(c);
            sample();
            if (clr_busy) cnt++;
            commit();
        end
        idle_inputs();
        check("sweep_len", cnt, 3);
        for (int a = 1; a < NR; a++) begin
            rd_addr1 = 2'(a);
            sample();
            check("swept_data", rd_data1, 64'h0);
            check("swept_busy", rd_busy1, 1'b0);
            commit();
        end

        // Reset in the middle of a sweep.
        write(2'd2, 64'd10);
        write(2'd3, 64'd11);
        clr_req = 1'b1;
        step();
        idle_inputs();
        step();
        rd_addr1 = 2'd2; rd_addr2 = 2'd3;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("rst_clr_busy", clr_busy, 1'b0);
        check("rst_data1", rd_data1, 64'h0);
        check("rst_data2", rd_data2, 64'h0);
        check("rst_busy1", rd_busy1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clr_req = 1'b1;
        step();
        idle_inputs();
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            sample();
            if (clr_busy) cnt++;
            commit();
        end
        check("sweep_len_after_rst", cnt, 3);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rd_addr1 = 2'($urandom);
            rd_addr2 = 2'($urandom);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = 2'($urandom);
            wr_data  = {$urandom, $urandom};
            rsv_en   = $urandom_range(0, 2) == 0;
            rsv_addr = 2'($urandom);
            clr_req  = $urandom_range(0, 15) == 0;
            step();
        end
        idle_inputs();

        // Wider instance: write/readback of every register, then a full sweep.
        for (int i = 1; i < SNR; i++) begin
            s_wr_en = 1'b1; s_wr_addr = 4'(i); s_wr_data = 32'hA500_0000 | (i * 32'h111);
            step();
        end
        s_wr_en = 1'b0;
        for (int i = 1; i < SNR; i++) begin
            s_rd_addr1 = 4'(i);
            sample();
            check("w16_readback", s_rd_data1, 32'hA500_0000 | (i * 32'h111));
            commit();
        end
        s_clr_req = 1'b1;
        step();
        s_clr_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            sample();
            if (s_clr_busy) cnt++;
            commit();
        end
        check("w16_sweep_len", cnt, 15);
        for (int i = 1; i < SNR; i++) begin
            s_rd_addr1 = 4'(i);
            sample();
            check("w16_swept_data", s_rd_data1, 32'h0);
            check("w16_swept_busy", s_rd_busy1, 1'b0);
            commit();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with a per-register pending-write scoreboard and a sequential clear engine, for the multicycle datapath. It provides two combinational read ports with same-cycle write bypass, one synchronous write port, and register 0 hard-wired to zero. The decode stage reserves destinations so hazards show up as busy flags. The control FSM can wipe the whole file with a multi-cycle clear sweep.

## Interface
- DATA_WIDTH, 64, register and data-bus width in bits
- NUM_REGS, 4, number of registers; power of two, ≥ 2
- ADDR_BITS, $clog2(NUM_REGS), register address width (derived; not overridden)

- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rd_addr1  input  ADDR_BITS  read port 1 address
- rd_addr2  input  ADDR_BITS  read port 2 address
- rd_data1  output  DATA_WIDTH  read port 1 data (combinational)
- rd_data2  output  DATA_WIDTH  read port 2 data (combinational)
- rd_busy1  output  1  register at rd_addr1 has a pending write
- rd_busy2  output  1  register at rd_addr2 has a pending write
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_BITS  write address
- wr_data  input  DATA_WIDTH  write data
- rsv_en  input  1  reserve strobe; marks rsv_addr pending
- rsv_addr  input  ADDR_BITS  register to reserve
- clr_req  input  1  start clear sweep (single-cycle pulse or level)
- clr_busy  output  1  clear sweep in progress

## Operation
- Storage
  - Registers 1..NUM_REGS-1 are flops.
  - Register 0 reads as 0 and is never pending.
  - Writes and reserves to address 0 are ignored.
- Read
  - rd_dataN = 0 when rd_addrN == 0.
  - Otherwise, when wr_en && wr_addr == rd_addrN, rd_dataN = wr_data (bypass).
  - Otherwise rd_dataN = the stored value.
- Write: when wr_en and wr_addr != 0, reg[wr_addr] <= wr_data at the rising edge.
- Scoreboard (pend[NUM_REGS-1:1])
  - rsv_en sets pend[rsv_addr].
  - wr_en clears pend[wr_addr].
  - Same address, same edge: set wins, so pend stays 1. This supports back-to-back reuse of a destination.
  - rd_busyN = pend[rd_addrN] && !(wr_en && wr_addr == rd_addrN). A bypassed writeback is therefore not busy.
  - rd_busyN = 0 for address 0.
- Clear FSM, states IDLE and CLEAR
  - IDLE → CLEAR on clr_req; idx <= 1.
  - In CLEAR, each edge: reg[idx] <= 0, pend[idx] <= 0, idx <= idx+1.
  - CLEAR → IDLE on the edge that clears idx == NUM_REGS-1.
  - clr_busy = 1 exactly while in CLEAR.
  - In CLEAR, wr_en and rsv_en are ignored (no state change).
  - In CLEAR, clr_req is ignored (no restart).
  - In CLEAR, reads return current stored values with no bypass, and rd_busy1/rd_busy2 are forced to 1 for nonzero addresses.
  - clr_req held high in IDLE starts a new sweep on every entry to IDLE.
- Reset (rst_n low, asynchronous): all registers 0, pend all 0, state IDLE, idx 1, clr_busy 0. Reset mid-sweep aborts the sweep immediately.

## Timing
- Read data and busy flags are combinational from addresses, the write port and the FSM state; there is no read latency.
- A write is visible from the stored value one cycle after wr_en, and the same cycle via bypass.
- A reserve is visible on rd_busy the cycle after rsv_en.
- Clear sweep
  - clr_busy rises the cycle after clr_req is sampled.
  - It stays high for NUM_REGS-1 cycles.
  - All registers read 0 and are not busy on the first cycle it is low.
- No combinational path from clr_req to any output.

## Test plan
- Reset and zero register: assert rst_n=0 mid-cycle → all rd_data 0 and rd_busy 0 immediately. Then write 64'hDEAD to addr 0 → reading addr 0 returns 0 and rd_busy 0.
- Write and bypass: wr_en=1, wr_addr=2, wr_data=64'h1234, rd_addr1=2 in the same cycle → rd_data1=64'h1234 that cycle. It still reads 64'h1234 after the edge with wr_en=0.
- Scoreboard
  - rsv_en addr 3 → rd_busy2=1 next cycle.
  - Writeback to addr 3 → rd_busy2=0 in the writeback cycle (bypass) and after.
  - rsv_en and wr_en to addr 3 on the same edge → rd_busy2 stays 1.
- Clear sweep (NUM_REGS=4, regs 1..3 = 5,6,7, reg 2 pending): pulse clr_req → clr_busy=1 for exactly 3 cycles. A wr_en to addr 1 during the sweep is ignored. Afterwards all regs read 0 and no register is busy.
- Reset mid-sweep: drop rst_n during cycle 2 of CLEAR → clr_busy=0 at once, all regs 0. A new clr_req after release runs a full 3-cycle sweep.
- Parameter sweep: DATA_WIDTH=32, NUM_REGS=16 → write then read back each of regs 1..15 with distinct values. Clear sweep lasts 15 cycles.
